// File: rtl/conv_mac.sv
// conv_mac: two-stage signed multiply-accumulate that sums TAPS products per window behind valid/ready handshakes.
// Define CONV_MAC_SAT_EN to saturate the accumulator instead of wrapping.
module conv_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int TAPS   = 9
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        Clear,
  input  logic                        InValid,
  output logic                        InReady,
  input  logic signed [DATA_W-1:0]    x,
  input  logic signed [DATA_W-1:0]    y,
  output logic                        OutValid,
  input  logic                        OutReady,
  output logic signed [ACC_W-1:0]     Result,
  output logic                        Overflow,
  output logic [$clog2(TAPS+1)-1:0]   TapCount,
  output logic signed [ACC_W-1:0]     AccOut
);
  localparam int TW = $clog2(TAPS+1);
`ifdef CONV_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif
  logic [TW-1:0] tap_q, tap_d;
  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_first_q, s1_first_d;
  logic signed [2*DATA_W-1:0] p_q, p_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, res_q, res_d, base, p_ext, sum, sum_fix;
  logic ovf_q, ovf_d, res_ovf_q, res_ovf_d, out_valid_q, out_valid_d;
  logic accept, fire, last_tap, wrap_ovf, done;
  assign InReady  = !Clear && !(s1_valid_q && s1_last_q);
  assign accept   = InValid && InReady;
  assign last_tap = tap_q == TW'(TAPS-1);
  // A held last product may only move on once the output slot is free or being read.
  assign fire     = s1_valid_q && !Clear && (!s1_last_q || !out_valid_q || OutReady);
  assign done     = fire && s1_last_q;
  assign base     = s1_first_q ? '0 : acc_q;
  assign p_ext    = ACC_W'(p_q);
  assign sum      = base + p_ext;
  assign wrap_ovf = (base[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
`ifdef CONV_MAC_SAT_EN
  assign sum_fix  = wrap_ovf ? (base[ACC_W-1] ? MIN : MAX) : sum;
`else
  assign sum_fix  = sum;
`endif
  always_comb begin
    tap_d       = Clear ? '0 : accept ? (last_tap ? '0 : tap_q + TW'(1)) : tap_q;
    s1_valid_d  = !Clear && (accept || (s1_valid_q && !fire));
    s1_last_d   = accept ? last_tap : s1_last_q;
    s1_first_d  = accept ? (tap_q == '0) : s1_first_q;
    p_d         = accept ? (2*DATA_W)'(x) * (2*DATA_W)'(y) : p_q;
    acc_d       = Clear ? '0 : fire ? sum_fix : acc_q;
    ovf_d       = (Clear || done) ? 1'b0 : ovf_q | (fire && wrap_ovf);
    res_d       = done ? sum_fix : res_q;
    res_ovf_d   = done ? (ovf_q | wrap_ovf) : res_ovf_q;
    out_valid_d = !Clear && (done || (out_valid_q && !OutReady));
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tap_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_first_q  <= 1'b0;
      p_q         <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      res_q       <= '0;
      res_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      tap_q       <= tap_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_first_q  <= s1_first_d;
      p_q         <= p_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      res_q       <= res_d;
      res_ovf_q   <= res_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign OutValid = out_valid_q;
  assign Result   = res_q;
  assign Overflow = res_ovf_q;
  assign TapCount = tap_q;
  assign AccOut   = acc_q;
endmodule

// File: tb/tb_conv_mac.sv
// tb_conv_mac: random and directed stimulus on a default conv_mac and an ACC_W=16/TAPS=3 instance,
// checked against a window-sum model built from plain integer arithmetic.
module tb_conv_mac;
  logic Clk = 1'b0;
  logic rst_n, clear, o_rdy, rnd;
  logic [1:0] iv, ir, ov, of;
  logic signed [7:0] x, y;
  logic signed [31:0] res_a, acc_a;
  logic signed [15:0] res_b, acc_b;
  logic [3:0] tc_a;
  logic [1:0] tc_b;
  int n_pass = 0, n_total = 0;
  int taken [2];
  longint psum [2];
  int pn [2];
  bit povf [2];
  typedef struct { longint r; bit o; } res_t;
  res_t q0[$], q1[$];
  res_t e;
  longint t, lim;
  int base_taken;

  always #5 Clk = ~Clk;

  conv_mac #(.DATA_W(8), .ACC_W(32), .TAPS(9)) dut_a (
    .Clk(Clk), .Reset_n(rst_n), .Clear(clear), .InValid(iv[0]), .InReady(ir[0]),
    .x(x), .y(y), .OutValid(ov[0]), .OutReady(o_rdy), .Result(res_a),
    .Overflow(of[0]), .TapCount(tc_a), .AccOut(acc_a));

  conv_mac #(.DATA_W(8), .ACC_W(16), .TAPS(3)) dut_b (
    .Clk(Clk), .Reset_n(rst_n), .Clear(clear), .InValid(iv[1]), .InReady(ir[1]),
    .x(x), .y(y), .OutValid(ov[1]), .OutReady(o_rdy), .Result(res_b),
    .Overflow(of[1]), .TapCount(tc_b), .AccOut(acc_b));

  task automatic check(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_total++;
    $display("FAIL %s: got timeout/unexpected event expected handshake", nm);
  endtask

  function automatic longint get_res(input int k);
    return (k == 0) ? longint'(res_a) : longint'(res_b);
  endfunction

  // Reference model: exact integer window sums, wrapped or clamped to the accumulator range.
  always @(negedge Clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        psum[k] = 0; pn[k] = 0; povf[k] = 1'b0;
        if (k == 0) q0.delete(); else q1.delete();
      end else begin
        if (ov[k] && o_rdy) begin
          if ((k == 0 ? q0.size() : q1.size()) == 0) fail(k == 0 ? "extra_result_a" : "extra_result_b");
          else begin
            if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
            check(k == 0 ? "model_res_a" : "model_res_b", get_res(k), e.r);
            check(k == 0 ? "model_ovf_a" : "model_ovf_b", longint'(of[k]), longint'(e.o));
            taken[k]++;
          end
        end
        if (clear) begin
          check("clear_inready", longint'(ir[k]), 0);
          psum[k] = 0; pn[k] = 0; povf[k] = 1'b0;
          if (k == 0) q0.delete(); else q1.delete();
        end else if (iv[k] && ir[k]) begin
          lim = longint'(1) << ((k == 0 ? 32 : 16) - 1);
          t = psum[k] + longint'(x) * longint'(y);
          if (t >= lim || t < -lim) begin
            povf[k] = 1'b1;
`ifdef CONV_MAC_SAT_EN
            t = (t < 0) ? -lim : lim - 1;
`else
            t = (t < 0) ? t + 2 * lim : t - 2 * lim;
`endif
          end
          psum[k] = t;
          pn[k]++;
          if (pn[k] == (k == 0 ? 9 : 3)) begin
            e.r = psum[k]; e.o = povf[k];
            if (k == 0) q0.push_back(e); else q1.push_back(e);
            psum[k] = 0; pn[k] = 0; povf[k] = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input int k, input int a, input int b);
    int n = 0;
    x = 8'(a); y = 8'(b); iv[k] = 1'b1;
    @(negedge Clk);
    while (!ir[k] && n < 64) begin
      @(posedge Clk); #1;
      if (rnd) o_rdy = 1'($urandom_range(0, 1));
      @(negedge Clk);
      n++;
    end
    if (!ir[k]) fail("send_timeout");
    @(posedge Clk); #1;
    iv[k] = 1'b0;
    if (rnd) o_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_out(input int k, input longint r, input bit o, input string nm);
    int n = 0;
    @(negedge Clk);
    while (!ov[k] && n < 64) begin @(negedge Clk); n++; end
    if (!ov[k]) fail(nm);
    else begin
      check(nm, get_res(k), r);
      check({nm, "_ovf"}, longint'(of[k]), longint'(o));
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; iv = '0; o_rdy = 1'b1; x = '0; y = '0; rnd = 1'b0;
    taken[0] = 0; taken[1] = 0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_outvalid", longint'(ov[0]), 0);
    check("rst_result", longint'(res_a), 0);
    check("rst_tapcount", longint'(tc_a), 0);
    check("rst_accout", longint'(acc_a), 0);
    check("rst_inready", longint'(ir[0]), 1);
    clear = 1'b1; #1;
    check("rst_inready_clear", longint'(ir[0]), 0);
    clear = 1'b0; #1;
    @(posedge Clk); #1;
    rst_n = 1'b1;
    @(posedge Clk); #1;

    for (int i = 1; i <= 9; i++) send(0, i, 1);
    check("lat_early", longint'(ov[0]), 0);
    check("bubble_inready", longint'(ir[0]), 0);
    @(posedge Clk); #1;
    check("lat_t2", longint'(ov[0]), 1);
    check("sum45", longint'(res_a), 45);
    check("sum45_ovf", longint'(of[0]), 0);
    check("ready_after_bubble", longint'(ir[0]), 1);

    send(0, -128, -128);
    check("tapcount_1", longint'(tc_a), 1);
    for (int i = 1; i < 9; i++) send(0, -128, -128);
    wait_out(0, 147456, 1'b0, "sum_pos");
    check("accout_final", longint'(acc_a), 147456);
    for (int i = 0; i < 9; i++) send(0, -128, 127);
    wait_out(0, -146304, 1'b0, "sum_neg");

    o_rdy = 1'b0;
    base_taken = taken[0];
    for (int i = 0; i < 18; i++) send(0, 2, 3);
    check("stall_valid", longint'(ov[0]), 1);
    check("stall_res", longint'(res_a), 54);
    for (int i = 0; i < 3; i++) begin
      check("stall_inready", longint'(ir[0]), 0);
      @(posedge Clk); #1;
      check("stall_hold", longint'(res_a), 54);
    end
    o_rdy = 1'b1;
    @(posedge Clk); #1;
    check("second_valid", longint'(ov[0]), 1);
    check("second_res", longint'(res_a), 54);
    check("second_inready", longint'(ir[0]), 1);
    @(posedge Clk); #1;
    check("second_taken", longint'(ov[0]), 0);
    check("no_loss", longint'(taken[0] - base_taken), 2);

    send(1, 127, 127);
    check("tapcount_b", longint'(tc_b), 1);
    send(1, 127, 127);
    send(1, 127, 127);
`ifdef CONV_MAC_SAT_EN
    wait_out(1, 32767, 1'b1, "b_overflow");
    check("b_accout", longint'(acc_b), 32767);
`else
    wait_out(1, -17149, 1'b1, "b_overflow");
    check("b_accout", longint'(acc_b), -17149);
`endif
    for (int i = 0; i < 3; i++) send(1, 1, 1);
    wait_out(1, 3, 1'b0, "b_clean");

    for (int i = 0; i < 4; i++) send(0, 5, 5);
    clear = 1'b1; iv[0] = 1'b1; x = 8'sd1; y = 8'sd1;
    @(negedge Clk);
    check("clear_drop", longint'(ir[0]), 0);
    @(posedge Clk); #1;
    clear = 1'b0; iv[0] = 1'b0;
    check("clear_tap", longint'(tc_a), 0);
    check("clear_acc", longint'(acc_a), 0);
    check("clear_valid", longint'(ov[0]), 0);
    for (int i = 0; i < 9; i++) send(0, 1, 1);
    wait_out(0, 9, 1'b0, "after_clear");

    for (int i = 0; i < 4; i++) send(0, 1, 1);
    rst_n = 1'b0; #1;
    check("mid_rst_tap", longint'(tc_a), 0);
    check("mid_rst_acc", longint'(acc_a), 0);
    check("mid_rst_res", longint'(res_a), 0);
    check("mid_rst_valid", longint'(ov[0]), 0);
    check("mid_rst_inready", longint'(ir[0]), 1);
    @(posedge Clk); #1;
    rst_n = 1'b1;
    o_rdy = 1'b0;
    for (int i = 0; i < 9; i++) send(0, 3, 3);
    wait_out(0, 81, 1'b0, "pre_reset");
    rst_n = 1'b0; #1;
    check("out_rst_valid", longint'(ov[0]), 0);
    check("out_rst_res", longint'(res_a), 0);
    @(posedge Clk); #1;
    rst_n = 1'b1; o_rdy = 1'b1;
    for (int i = 0; i < 9; i++) send(0, 1, 2);
    wait_out(0, 18, 1'b0, "after_reset");

    rnd = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 49);
      if (r == 0) begin
        clear = 1'b1; iv[0] = 1'($urandom_range(0, 1));
        @(posedge Clk); #1;
        clear = 1'b0; iv[0] = 1'b0;
      end else if (r < 8) begin
        @(posedge Clk); #1;
        o_rdy = 1'($urandom_range(0, 1));
      end else begin
        send(($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 255)) - 128,
             int'($urandom_range(0, 255)) - 128);
      end
    end
    rnd = 1'b0; o_rdy = 1'b1;
    repeat (20) @(posedge Clk);
    #1;
    check("drain_a", longint'(q0.size()), 0);
    check("drain_b", longint'(q1.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/conv_mac.md
# conv_mac

Parametrised, pipelined signed multiply-accumulate engine for the convolution datapath. It accepts a stream of (pixel, weight) pairs over a valid/ready handshake, sums exactly `TAPS` products per window, and presents each window's sum on a held output register with its own valid/ready handshake. It generalises the fixed 8-bit single-accumulator MAC with:
- configurable data width, accumulator width and window length;
- automatic window framing;
- output backpressure;
- overflow detection.

## Interface
Parameters:
- `DATA_W`, 8: signed width of `x` and `y`.
- `ACC_W`, 32: signed accumulator and result width. Must satisfy `ACC_W >= 2*DATA_W`.
- `TAPS`, 9: products per window (9 = 3x3 kernel). Must satisfy `TAPS >= 1`.

Ports:
- `Clk`  in  1  rising-edge clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Clear`  in  1  synchronous active-high abort/flush.
- `InValid`  in  1  input beat valid.
- `InReady`  out  1  engine can accept a beat.
- `x`  in  `DATA_W`  signed pixel.
- `y`  in  `DATA_W`  signed weight.
- `OutValid`  out  1  `Result` holds an unread window sum.
- `OutReady`  in  1  consumer takes `Result`.
- `Result`  out  `ACC_W`  signed window sum.
- `Overflow`  out  1  signed overflow occurred in the window reported in `Result`.
- `TapCount`  out  `$clog2(TAPS+1)`  beats accepted in the current window (debug/sim).
- `AccOut`  out  `ACC_W`  live accumulator (debug/sim).

## Operation
- A beat is accepted when `InValid && InReady`.
- **Stage 1 (product):**
  - Registers `P = x*y` at full `2*DATA_W` signed precision.
  - Registers flag `S1Last = (TapCount == TAPS-1)`.
  - `TapCount` increments on each accepted beat and wraps to 0 after the last tap.
- **Stage 2 (accumulate):**
  - Computes `Acc <= (first ? 0 : Acc) + sext(P)` to `ACC_W`; `first` marks tap 0 of a window.
  - On the last product of a window, writes the sum to `Result` and `Overflow`, sets `OutValid`, and resets the internal overflow flag.
- **Overflow:** set when the operands have equal sign and the sum sign differs, or when the value is clamped (see Configuration). The flag is sticky within a window.
- **Backpressure:**
  - `InReady = !Clear && !(S1Valid && S1Last)`.
  - Stage 1 holding a last product advances only when `!OutValid || OutReady`.
  - Non-last products always advance.
- **Output handshake:** `OutValid` drops after a cycle with `OutValid && OutReady`, unless a new result is written in that same cycle, in which case it stays high with the new value.
- **`Clear`:**
  - Flushes stage 1.
  - Zeroes `TapCount`, `Acc`, `OutValid` and the overflow flag.
  - Wins over a simultaneous beat; that beat is not accepted.
- **Reset (`Reset_n` low, any time):**
  - All registers go to 0: `OutValid=0`, `Result=0`, `Overflow=0`, `TapCount=0`, `AccOut=0`.
  - Any partial window is discarded.
  - `InReady` follows its equation, i.e. it equals `!Clear` during and after reset.

## Timing
- Latency: last beat accepted in cycle t gives `OutValid=1` in cycle t+2 when the output slot is free.
- Throughput is one beat per cycle, except for one bubble cycle after each window's last beat. For `TAPS=1` this gives one beat every 2 cycles.
- A result stalled by `OutReady=0` holds `Result`, `Overflow` and `InReady=0` until it is taken.
- Within a window, `x` and `y` are sampled only on accepted beats; values on other cycles are don't-care.

## Configuration
- Macro `CONV_MAC_SAT_EN`.
- Defined: stage-2 addition saturates to `+2^(ACC_W-1)-1` / `-2^(ACC_W-1)`, and `Overflow` is set when clamping occurs.
- Undefined: two's-complement wrap; `Overflow` is still set on a signed overflow.
- Ports and timing are identical in both builds.

## Test plan
- Defaults, 9 beats `x=1..9`, `y=1`, `OutReady=1` -> one `Result=45`, `Overflow=0`, `OutValid` high 2 cycles after the 9th beat; next window accepted after a 1-cycle bubble.
- Defaults, 9 beats `x=-128`, `y=-128` -> `Result=147456`. Then 9 beats `x=-128`, `y=127` -> `Result=-146304`.
- `OutReady=0` across two back-to-back windows (`x=2`, `y=3`, sum 54) -> `Result=54` held, `InReady=0` while stage 1 holds the second window's last product. Raise `OutReady` -> second 54 appears; no beat lost or duplicated.
- `ACC_W=16`, `TAPS=3`, `x=y=127` (16129 each) -> with `CONV_MAC_SAT_EN` `Result=32767`; without it `Result=-17149`; `Overflow=1` in both builds. The next clean window reports `Overflow=0`.
- `Clear` pulsed after 4 of 9 beats, then 9 beats `x=1`, `y=1` -> `Result=9`; `Clear` coincident with `InValid` -> `InReady=0` and the beat is dropped.
- `Reset_n` asserted mid-window and while `OutValid=1` -> all outputs 0 immediately; after release, 9 beats `x=1`, `y=2` -> `Result=18`.
